// File: rtl/cacheline_adapter.sv
// Bridges 256-bit cache-line reads/writes to a 64-bit banked memory: one read request + 4 tagged return beats, or 4 write beats.
// Latency: read resp 1 cycle after the 4th matching beat, write resp after the 4th accepted beat; bmem_ready stalls the request/beat.
module cacheline_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dfp_addr,
  input  logic         dfp_read,
  input  logic         dfp_write,
  input  logic [255:0] dfp_wdata,
  output logic [255:0] dfp_rdata,
  output logic         dfp_resp,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [31:0]  bmem_raddr,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] RD_REQ     = 3'd1;
  localparam logic [2:0] RD_COLLECT = 3'd2;
  localparam logic [2:0] WR_BEAT    = 3'd3;
  localparam logic [2:0] RESP       = 3'd4;

  logic [2:0]   state;
  logic [1:0]   cnt;
  logic [31:0]  addr_q;
  logic [255:0] line_q;
  logic         beat_hit;

  // Return beats are tagged; anything not addressed to our line is dropped.
  assign beat_hit = bmem_rvalid && (bmem_raddr == addr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      addr_q    <= 32'd0;
      line_q    <= '0;
      dfp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dfp_read) begin
            addr_q <= {dfp_addr[31:5], 5'b0};
            cnt    <= 2'd0;
            state  <= RD_REQ;
          end else if (dfp_write) begin
            addr_q <= {dfp_addr[31:5], 5'b0};
            line_q <= dfp_wdata;
            cnt    <= 2'd0;
            state  <= WR_BEAT;
          end
        end
        RD_REQ: begin
          if (bmem_ready) begin
            cnt   <= 2'd0;
            state <= RD_COLLECT;
          end
        end
        RD_COLLECT: begin
          if (beat_hit) begin
            line_q[{cnt, 6'd0} +: 64] <= bmem_rdata;
            cnt <= cnt + 2'd1;
            // Publish the whole line at once so dfp_rdata never shows a partial line.
            if (cnt == 2'd3) begin
              dfp_rdata <= {bmem_rdata, line_q[191:0]};
              state     <= RESP;
            end
          end
        end
        WR_BEAT: begin
          if (bmem_ready) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bmem_read  = (state == RD_REQ);
    bmem_write = (state == WR_BEAT);
    bmem_addr  = (bmem_read || bmem_write) ? addr_q : 32'd0;
    bmem_wdata = bmem_write ? line_q[{cnt, 6'd0} +: 64] : 64'd0;
    dfp_resp   = (state == RESP);
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: transaction-level model compared every cycle plus literal spot checks.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  dfp_addr = '0;
  logic         dfp_read = 1'b0;
  logic         dfp_write = 1'b0;
  logic [255:0] dfp_wdata = '0;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready = 1'b0;
  logic [31:0]  bmem_raddr = '0;
  logic [63:0]  bmem_rdata = '0;
  logic         bmem_rvalid = 1'b0;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: which job is in flight, what is still owed, what line was last returned.
  bit           m_rd = 0, m_wr = 0, m_resp = 0, m_req = 0;
  int           m_widx = 0;
  logic [31:0]  m_addr = '0;
  logic [255:0] m_wline = '0;
  logic [255:0] m_last = '0;
  logic [63:0]  m_beats[$];

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_rd = 0; m_wr = 0; m_resp = 0; m_req = 0; m_widx = 0;
      m_addr = '0; m_wline = '0; m_last = '0; m_beats.delete();
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_rd) begin
      if (m_req) begin
        if (bmem_ready) m_req = 0;
      end else if (bmem_rvalid && bmem_raddr == m_addr) begin
        m_beats.push_back(bmem_rdata);
        if (m_beats.size() == 4) begin
          m_last = {m_beats[3], m_beats[2], m_beats[1], m_beats[0]};
          m_rd = 0;
          m_resp = 1;
        end
      end
    end else if (m_wr) begin
      if (bmem_ready) begin
        m_widx++;
        if (m_widx == 4) begin
          m_wr = 0;
          m_resp = 1;
        end
      end
    end else if (dfp_read) begin
      m_rd = 1; m_req = 1; m_addr = dfp_addr & 32'hFFFF_FFE0; m_beats.delete();
    end else if (dfp_write) begin
      m_wr = 1; m_widx = 0; m_addr = dfp_addr & 32'hFFFF_FFE0; m_wline = dfp_wdata;
    end
  end

  int          n_rd = 0;
  int          n_resp = 0;
  logic [63:0] wlog[$];

  initial forever begin
    @(negedge clk);
    check("cyc_bmem_read", bmem_read, m_rd && m_req);
    check("cyc_bmem_write", bmem_write, m_wr);
    check("cyc_bmem_addr", bmem_addr, (m_wr || (m_rd && m_req)) ? m_addr : 32'd0);
    check("cyc_dfp_resp", dfp_resp, m_resp);
    check("cyc_dfp_rdata", dfp_rdata, m_last);
    if (m_wr) check("cyc_bmem_wdata", bmem_wdata, m_wline[m_widx*64 +: 64]);
    if (bmem_read) n_rd++;
    if (bmem_write) wlog.push_back(bmem_wdata);
    if (dfp_resp) n_resp++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic give_beat(input logic [31:0] a, input logic [63:0] d);
    bmem_rvalid = 1'b1; bmem_raddr = a; bmem_rdata = d;
    cyc();
    bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
  endtask

  task automatic wait_resp(input string name);
    int k;
    k = 0;
    while (!dfp_resp && k < 20) begin
      cyc();
      k++;
    end
    check(name, dfp_resp, 1'b1);
  endtask

  int          pat[6] = '{1, 0, 1, 1, 0, 1};
  logic [63:0] wexp[6] = '{64'd1, 64'd1, 64'd2, 64'd3, 64'd3, 64'd4};
  int          resp_before;

  initial begin
    cyc(); cyc();
    check("rst_rdata", dfp_rdata, 256'h0);
    check("rst_outs", {bmem_read, bmem_write, dfp_resp, bmem_addr}, 35'h0);
    rst = 1'b0;
    cyc();

    // Plain read, memory always ready, consecutive beats.
    n_rd = 0;
    bmem_ready = 1'b1; dfp_addr = 32'h6000_0020; dfp_read = 1'b1;
    cyc();
    check("t1_req", bmem_read, 1'b1);
    check("t1_addr", bmem_addr, 32'h6000_0020);
    cyc();
    check("t1_req_done", bmem_read, 1'b0);
    give_beat(32'h6000_0020, 64'h1111_1111_1111_1111);
    give_beat(32'h6000_0020, 64'h2222_2222_2222_2222);
    give_beat(32'h6000_0020, 64'h3333_3333_3333_3333);
    give_beat(32'h6000_0020, 64'h4444_4444_4444_4444);
    check("t1_resp_lat", dfp_resp, 1'b1);
    check("t1_line", dfp_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    dfp_read = 1'b0;
    cyc();
    check("t1_resp_pulse", dfp_resp, 1'b0);
    check("t1_nreads", n_rd, 1);

    // Unaligned address, memory stalls the request for 3 cycles.
    n_rd = 0;
    bmem_ready = 1'b0; dfp_addr = 32'h1234_5677; dfp_read = 1'b1;
    cyc();
    check("t2_addr", bmem_addr, 32'h1234_5660);
    repeat (3) cyc();
    bmem_ready = 1'b1;
    cyc();
    check("t2_req_done", bmem_read, 1'b0);
    check("t2_nreads", n_rd, 4);
    for (int i = 0; i < 4; i++) give_beat(32'h1234_5660, {8{8'hA0 + 8'(i)}});
    wait_resp("t2_resp");
    check("t2_line", dfp_rdata, {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                                 64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0});
    dfp_read = 1'b0;
    cyc();

    // Gapped beats with a stray tag in between.
    dfp_addr = 32'h0000_1000; dfp_read = 1'b1;
    cyc(); cyc();
    give_beat(32'h0000_1000, 64'h0000_0000_0000_00B0);
    cyc(); cyc();
    give_beat(32'h0000_1000, 64'h0000_0000_0000_00B1);
    cyc();
    give_beat(32'hDEAD_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc();
    give_beat(32'h0000_1000, 64'h0000_0000_0000_00B2);
    cyc(); cyc();
    check("t3_no_early_resp", dfp_resp, 1'b0);
    give_beat(32'h0000_1000, 64'h0000_0000_0000_00B3);
    check("t3_resp", dfp_resp, 1'b1);
    check("t3_line", dfp_rdata, {64'hB3, 64'hB2, 64'hB1, 64'hB0});
    dfp_read = 1'b0;
    cyc();

    // Write with bmem_ready toggling.
    n_rd = 0; wlog.delete();
    dfp_addr = 32'h0000_2040; dfp_wdata = {64'd4, 64'd3, 64'd2, 64'd1}; dfp_write = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bmem_ready = pat[i][0];
      cyc();
    end
    bmem_ready = 1'b1;
    wait_resp("t4_resp");
    check("t4_nbeats", wlog.size(), 6);
    for (int i = 0; i < 6 && i < wlog.size(); i++) check($sformatf("t4_wdata%0d", i), wlog[i], wexp[i]);
    check("t4_nreads", n_rd, 0);
    dfp_write = 1'b0;
    cyc();
    check("t4_resp_pulse", dfp_resp, 1'b0);

    // Read and write requested together: read wins, write follows.
    wlog.delete();
    dfp_addr = 32'h0000_3000; dfp_wdata = {4{64'h5A5A_0000_0000_0001}};
    dfp_read = 1'b1; dfp_write = 1'b1;
    cyc();
    check("t5_read_first", {bmem_read, bmem_write}, 2'b10);
    cyc();
    for (int i = 0; i < 4; i++) give_beat(32'h0000_3000, 64'(i + 'h70));
    check("t5_rd_resp", dfp_resp, 1'b1);
    check("t5_no_write_yet", wlog.size(), 0);
    dfp_read = 1'b0;
    cyc();
    wait_resp("t5_wr_resp");
    check("t5_write_beats", wlog.size(), 4);
    dfp_write = 1'b0;
    cyc();

    // Reset in the middle of a read.
    resp_before = n_resp;
    dfp_addr = 32'h0000_4000; dfp_read = 1'b1;
    cyc(); cyc();
    give_beat(32'h0000_4000, 64'hC0);
    give_beat(32'h0000_4000, 64'hC1);
    rst = 1'b1; dfp_read = 1'b0;
    give_beat(32'h0000_4000, 64'hC2);
    rst = 1'b0;
    check("t6_outs_zero", {bmem_read, bmem_write, dfp_resp, bmem_addr}, 35'h0);
    check("t6_rdata_zero", dfp_rdata, 256'h0);
    give_beat(32'h0000_4000, 64'hC3);
    cyc();
    check("t6_no_resp", n_resp, resp_before);
    dfp_addr = 32'h0000_5000; dfp_read = 1'b1;
    cyc(); cyc();
    give_beat(32'h0000_4000, 64'hC3);
    for (int i = 0; i < 4; i++) give_beat(32'h0000_5000, 64'(i + 'hD0));
    check("t6_resp", dfp_resp, 1'b1);
    check("t6_line", dfp_rdata, {64'hD3, 64'hD2, 64'hD1, 64'hD0});
    dfp_read = 1'b0;
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
